// File: rtl/dataflow_deadlock_monitor.sv
// rtl/dataflow_deadlock_monitor.sv - stall-based deadlock detector with wait-for chain report stream
module dataflow_deadlock_monitor #(
  parameter int PROC_NUM = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [CNT_W-1:0]             stall_thresh,
  input  logic [PROC_NUM-1:0]          blk_vec,
  input  logic [PROC_NUM*PROC_NUM-1:0] dep_vec,
  output logic                         dl_detect,
  output logic [PROC_NUM-1:0]          origin_vec,
  output logic                         rpt_valid,
  input  logic                         rpt_ready,
  output logic [IDX_W-1:0]             rpt_proc_idx,
  output logic [IDX_W:0]               rpt_cycle_id,
  output logic                         rpt_last,
  output logic                         rpt_open,
  output logic                         rpt_done
);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_EMIT, S_DONE} state_t;

  state_t                            state, state_nxt;
  logic [CNT_W-1:0]                  cnt [PROC_NUM];
  logic [PROC_NUM-1:0]               hung;
  logic [PROC_NUM-1:0]               det_reg;
  logic [PROC_NUM-1:0]               done_reg;
  logic [PROC_NUM-1:0]               pend;
  logic [PROC_NUM-1:0][PROC_NUM-1:0] dep_reg;
  logic [IDX_W-1:0]                  origin;
  logic [IDX_W-1:0]                  cur;
  logic [IDX_W-1:0]                  step;
  logic [IDX_W-1:0]                  pick_idx;
  logic [IDX_W-1:0]                  nxt;
  logic [IDX_W:0]                    cycle_id;
  logic                              has_nxt;
  logic                              nxt_seen;
  logic                              closed;
  logic                              open_chain;
  logic                              last_entry;

  // Per-process stall counters: run while blocked and enabled, saturate at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROC_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PROC_NUM; i++) begin
        if (clear || !enable || !blk_vec[i]) cnt[i] <= '0;
        else if (cnt[i] != '1)               cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Hung flags; a zero threshold disables detection entirely
  always_comb begin
    hung = '0;
    for (int i = 0; i < PROC_NUM; i++)
      hung[i] = (stall_thresh != '0) && (cnt[i] >= stall_thresh);
  end

  // Lowest hung process not yet reported becomes the next chain origin
  always_comb begin
    pend     = det_reg & ~done_reg;
    pick_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--)
      if (pend[i]) pick_idx = IDX_W'(i);
  end

  // Chain successor and termination; the current entry counts as already reported
  always_comb begin
    nxt     = '0;
    has_nxt = 1'b0;
    for (int j = PROC_NUM - 1; j >= 0; j--) begin
      if (dep_reg[cur][j] && det_reg[j]) begin
        nxt     = IDX_W'(j);
        has_nxt = 1'b1;
      end
    end
    nxt_seen   = done_reg[nxt] || (nxt == cur);
    closed     = has_nxt && (nxt == origin);
    open_chain = !closed && (!has_nxt || nxt_seen || (step == IDX_W'(PROC_NUM - 1)));
    last_entry = closed || open_chain;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; clear overrides any handshake in the same cycle
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (|hung) state_nxt = S_PICK;
        S_PICK:  state_nxt = (pend == '0) ? S_DONE : S_EMIT;
        S_EMIT:  if (rpt_ready && last_entry) state_nxt = S_PICK;
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Snapshot capture and chain-walk bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      det_reg  <= '0;
      dep_reg  <= '0;
      done_reg <= '0;
      cycle_id <= '0;
      origin   <= '0;
      cur      <= '0;
      step     <= '0;
    end else if (clear) begin
      det_reg  <= '0;
      done_reg <= '0;
      cycle_id <= '0;
      origin   <= '0;
      cur      <= '0;
      step     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|hung) begin
            det_reg  <= hung;
            dep_reg  <= dep_vec & {PROC_NUM{hung}};
            done_reg <= '0;
            cycle_id <= (IDX_W + 1)'(1);
          end
        end
        S_PICK: begin
          if (pend != '0) begin
            origin <= pick_idx;
            cur    <= pick_idx;
            step   <= '0;
          end
        end
        S_EMIT: begin
          if (rpt_ready) begin
            done_reg[cur] <= 1'b1;
            step          <= step + 1'b1;
            if (last_entry) cycle_id <= cycle_id + 1'b1;
            else            cur      <= nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Report port and status outputs decoded from registered state
  always_comb begin
    dl_detect    = |det_reg;
    rpt_valid    = (state == S_EMIT);
    rpt_done     = (state == S_DONE);
    rpt_proc_idx = cur;
    rpt_cycle_id = cycle_id;
    rpt_last     = (state == S_EMIT) && last_entry;
    rpt_open     = (state == S_EMIT) && open_chain;
    origin_vec   = '0;
    if (state == S_EMIT) origin_vec[origin] = 1'b1;
  end

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// tb/tb_dataflow_deadlock_monitor.sv - model-checked directed bench for dataflow_deadlock_monitor
module tb_dataflow_deadlock_monitor;
  localparam int P  = 4;
  localparam int IW = 2;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            clear = 1'b0;
  logic [CW-1:0]   stall_thresh = '0;
  logic [P-1:0]    blk_vec = '0;
  logic [P*P-1:0]  dep_vec = '0;
  logic            rpt_ready = 1'b0;
  logic            dl_detect;
  logic [P-1:0]    origin_vec;
  logic            rpt_valid;
  logic [IW-1:0]   rpt_proc_idx;
  logic [IW:0]     rpt_cycle_id;
  logic            rpt_last;
  logic            rpt_open;
  logic            rpt_done;

  dataflow_deadlock_monitor #(.PROC_NUM(P), .IDX_W(IW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .stall_thresh(stall_thresh), .blk_vec(blk_vec), .dep_vec(dep_vec),
    .dl_detect(dl_detect), .origin_vec(origin_vec), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_proc_idx(rpt_proc_idx), .rpt_cycle_id(rpt_cycle_id),
    .rpt_last(rpt_last), .rpt_open(rpt_open), .rpt_done(rpt_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected output timeline: a bubble slot (no entry) precedes every chain and the
  // final DONE; bubbles last one cycle, entries last until accepted.
  typedef struct {
    bit valid;
    int idx;
    int id;
    bit last;
    bit opn;
    int origin;
  } slot_t;

  slot_t      m_q[$];
  int         m_cnt[P];
  bit [P-1:0] m_det;
  bit         m_active;
  bit         m_done;

  function automatic void push_bubble();
    slot_t b;
    b.valid = 0; b.idx = 0; b.id = 0; b.last = 0; b.opn = 0; b.origin = 0;
    m_q.push_back(b);
  endfunction

  function automatic void build_report(input bit [P-1:0] det, input bit [P*P-1:0] dep);
    bit [P-1:0] seen;
    int id, org, cur, nxt, steps;
    bit fin;
    slot_t s;
    seen = '0;
    id = 1;
    m_q.delete();
    while ((det & ~seen) != 0) begin
      org = -1;
      for (int i = P - 1; i >= 0; i--) if (det[i] && !seen[i]) org = i;
      push_bubble();
      cur = org;
      steps = 0;
      fin = 0;
      while (!fin) begin
        seen[cur] = 1;
        nxt = -1;
        for (int j = P - 1; j >= 0; j--) if (dep[cur*P+j] && det[j]) nxt = j;
        s.valid = 1; s.idx = cur; s.id = id; s.origin = org; s.last = 0; s.opn = 0;
        if (nxt == org) s.last = 1;
        else if (nxt < 0 || seen[nxt] || steps == P - 1) begin
          s.last = 1;
          s.opn  = 1;
        end
        m_q.push_back(s);
        fin = s.last;
        cur = nxt;
        steps++;
      end
      id++;
    end
    push_bubble();
  endfunction

  // Behavioural model advanced on the same edges as the design
  always @(posedge clock or posedge reset) begin
    bit [P-1:0] m_hung;
    if (reset) begin
      for (int i = 0; i < P; i++) m_cnt[i] = 0;
      m_det = '0; m_active = 0; m_done = 0;
      m_q.delete();
    end else begin
      for (int i = 0; i < P; i++) m_hung[i] = (stall_thresh != 0) && (m_cnt[i] >= int'(stall_thresh));
      if (clear) begin
        m_det = '0; m_active = 0; m_done = 0;
        m_q.delete();
      end else if (m_active) begin
        if (!m_q[0].valid || rpt_ready) void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (!m_done && m_hung != 0) begin
        m_det = m_hung;
        build_report(m_hung, dep_vec);
        m_active = 1;
      end
      for (int i = 0; i < P; i++)
        m_cnt[i] = (clear || !enable || !blk_vec[i]) ? 0 : ((m_cnt[i] == CNT_MAX) ? CNT_MAX : m_cnt[i] + 1);
    end
  end

  int log_q[$];
  int exp_q[$];

  // Per-cycle comparison against the model, plus a log of accepted entries
  always @(negedge clock) begin
    bit ev;
    ev = m_active && (m_q.size() > 0) && m_q[0].valid;
    check("dl_detect", dl_detect, int'(m_det != 0));
    check("rpt_valid", rpt_valid, int'(ev));
    check("rpt_done", rpt_done, int'(m_done));
    if (ev) begin
      check("rpt_proc_idx", rpt_proc_idx, m_q[0].idx);
      check("rpt_cycle_id", rpt_cycle_id, m_q[0].id);
      check("rpt_last", rpt_last, int'(m_q[0].last));
      check("rpt_open", rpt_open, int'(m_q[0].opn));
      check("origin_vec", origin_vec, 1 << m_q[0].origin);
    end else begin
      check("origin_vec_idle", origin_vec, 0);
    end
    if (!reset && !clear && rpt_valid && rpt_ready)
      log_q.push_back(int'(rpt_proc_idx) * 1000 + int'(rpt_cycle_id) * 100 + int'(rpt_last) * 10 + int'(rpt_open));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!rpt_valid && k < budget) begin step(1); k++; end
    check({name, "_valid_wait"}, rpt_valid, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!rpt_done && k < budget) begin step(1); k++; end
    check({name, "_done_wait"}, rpt_done, 1);
  endtask

  // Entry code: idx*1000 + cycle_id*100 + last*10 + open
  task automatic expect_entry(input int code);
    exp_q.push_back(code);
  endtask

  task automatic check_log(input string name);
    check({name, "_entry_count"}, log_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) check({name, "_entry"}, log_q[k], exp_q[k]);
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic restart(input int thr, input bit [P-1:0] blk, input bit [P*P-1:0] dep, input bit rdy);
    blk_vec = '0;
    clear = 1;
    step(1);
    clear = 0;
    stall_thresh = CW'(thr);
    blk_vec = blk;
    dep_vec = dep;
    rpt_ready = rdy;
  endtask

  initial begin
    enable = 1; rpt_ready = 1; stall_thresh = 4; blk_vec = 4'b0001; dep_vec = '0;
    step(2);
    check("reset_dl_detect", dl_detect, 0);
    check("reset_rpt_valid", rpt_valid, 0);
    reset = 0;

    // Single hung process, no dependences
    step(4);
    check("t1_dl_after_edge4", dl_detect, 0);
    step(1);
    check("t1_dl_after_edge5", dl_detect, 1);
    step(1);
    check("t1_first_valid", rpt_valid, 1);
    check("t1_first_idx", rpt_proc_idx, 0);
    wait_done("t1", 20);
    expect_entry(111);
    check_log("t1");

    // Two-process cycle 0<->1
    restart(3, 4'b0011, 16'h0012, 1);
    wait_done("t2", 40);
    expect_entry(100); expect_entry(1110);
    check_log("t2");

    // Two independent cycles {0,1} and {2,3}
    restart(3, 4'b1111, 16'h4812, 1);
    wait_done("t3", 40);
    expect_entry(100); expect_entry(1110); expect_entry(2200); expect_entry(3210);
    check_log("t3");

    // Open chain 0->1->2 with backpressure on the first entry
    restart(3, 4'b0111, 16'h0042, 0);
    wait_valid("t4", 20);
    for (int k = 0; k < 5; k++) begin
      check("t4_stall_valid", rpt_valid, 1);
      check("t4_stall_idx", rpt_proc_idx, 0);
      check("t4_stall_id", rpt_cycle_id, 1);
      step(1);
    end
    rpt_ready = 1;
    wait_done("t4", 40);
    expect_entry(100); expect_entry(1100); expect_entry(2111);
    check_log("t4");

    // Self-dependence is a closed one-entry chain
    restart(2, 4'b0100, 16'h0400, 1);
    wait_done("t5", 30);
    expect_entry(2110);
    check_log("t5");

    // Second chain runs into an already-reported process and ends open
    restart(2, 4'b0111, 16'h0212, 1);
    wait_done("t6", 40);
    expect_entry(100); expect_entry(1110); expect_entry(2211);
    check_log("t6");

    // Clear coincident with an accepted entry
    restart(3, 4'b1111, 16'h4812, 1);
    wait_valid("t7", 20);
    clear = 1;
    step(1);
    clear = 0;
    check("t7_dl_after_clear", dl_detect, 0);
    check("t7_valid_after_clear", rpt_valid, 0);
    check("t7_done_after_clear", rpt_done, 0);
    step(3);
    check("t7_counters_restarted", dl_detect, 0);
    step(1);
    check("t7_redetect", dl_detect, 1);
    wait_done("t7", 40);
    expect_entry(100); expect_entry(1110); expect_entry(2200); expect_entry(3210);
    check_log("t7");

    // Reset in the middle of a report
    restart(3, 4'b1111, 16'h4812, 1);
    wait_valid("t8", 20);
    step(1);
    reset = 1;
    #1;
    check("t8_valid_in_reset", rpt_valid, 0);
    check("t8_dl_in_reset", dl_detect, 0);
    check("t8_idx_in_reset", rpt_proc_idx, 0);
    step(1);
    expect_entry(100);
    check_log("t8");

    // Zero threshold never detects
    stall_thresh = 0;
    blk_vec = 4'b1111;
    reset = 0;
    step(1000);
    check("t9_thresh0_dl", dl_detect, 0);
    check("t9_thresh0_valid", rpt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
